// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART transmit path: FSM encodings,
// parity/stop configuration codes and oversampling tick counts.
package uart_pkg;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned STOP_TICKS_1   = 16;
  localparam int unsigned STOP_TICKS_1P5 = 24;
  localparam int unsigned STOP_TICKS_2   = 32;
  localparam int unsigned TCNT_W         = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  // Final tick index of the stop period; encoding 11 falls through to two stop bits.
  function automatic logic [TCNT_W-1:0] stop_last(input logic [1:0] mode);
    case (mode)
      STOP_1:   stop_last = TCNT_W'(STOP_TICKS_1 - 1);
      STOP_1P5: stop_last = TCNT_W'(STOP_TICKS_1P5 - 1);
      STOP_2:   stop_last = TCNT_W'(STOP_TICKS_2 - 1);
      default:  stop_last = TCNT_W'(STOP_TICKS_2 - 1);
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Ready/valid byte stream from the host-side producer into the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DBIT = 8
) ();
  logic [DBIT-1:0] s_data;
  logic            s_valid;
  logic            s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Programmable divider producing a registered one-cycle 16x oversampling tick;
// restart reloads the divisor and realigns the count to the new frame.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_load,
  output logic             tick,
  output logic             tick_nxt_c
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_n;

  // tick is high exactly in cycles where the count equals the latched divisor
  always_comb begin
    cnt_n      = (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);
    tick_nxt_c = (cnt_n == div_q);
    if (restart) begin
      cnt_n      = '0;
      tick_nxt_c = (div_load == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      tick  <= tick_nxt_c;
      if (restart) div_q <= div_load;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: ready/valid input FIFO feeding a
// start/data/parity/stop serialiser driven by a 16x oversampling tick.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  uart_tx_cfg_if.slave                    stream,
  input  logic [1:0]                      parity_mode,
  input  logic [1:0]                      stop_mode,
  input  logic [DIV_W-1:0]                baud_div,
  output logic                            tx,
  output logic                            busy,
  output logic                            tx_done_tick,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BCNT_W = $clog2(DBIT + 1);
  localparam logic [TCNT_W-1:0] BIT_LAST  = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DBIT - 1);

  // FIFO storage and bookkeeping
  logic [DBIT-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [LVL_W-1:0] count_q;
  logic [LVL_W-1:0] count_n;
  logic             ready_q;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [DBIT-1:0]  head;

  // Serialiser state
  logic [2:0]        state_q,     state_n;
  logic [TCNT_W-1:0] tcnt_q,      tcnt_n;
  logic [BCNT_W-1:0] bcnt_q,      bcnt_n;
  logic [DBIT-1:0]   shift_q,     shift_n;
  logic              par_bit_q,   par_bit_n;
  logic              par_en_q,    par_en_n;
  logic [TCNT_W-1:0] stop_last_q, stop_last_n;
  logic              tx_q,        tx_n;
  logic              busy_q;
  logic              done_q,      done_n;
  logic              tick;
  logic              tick_nxt_c;

  assign full  = (count_q == LVL_FULL);
  assign empty = (count_q == '0);
  assign push  = stream.s_valid && !full;
  assign head  = mem[rptr_q];

  always_comb begin
    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + LVL_W'(1);
      2'b01:   count_n = count_q - LVL_W'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_n;
      ready_q <= (count_n != LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= stream.s_data;
  end

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk        (clk),
    .reset      (reset),
    .restart    (pop),
    .div_load   (baud_div),
    .tick       (tick),
    .tick_nxt_c (tick_nxt_c)
  );

  // Next-state logic; a pop from IDLE or the final stop tick starts a new frame
  always_comb begin
    state_n     = state_q;
    tcnt_n      = tcnt_q;
    bcnt_n      = bcnt_q;
    shift_n     = shift_q;
    par_bit_n   = par_bit_q;
    par_en_n    = par_en_q;
    stop_last_n = stop_last_q;
    pop         = 1'b0;
    tx_n        = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == BIT_LAST) begin
            state_n = ST_DATA;
            tcnt_n  = '0;
            bcnt_n  = '0;
          end else begin
            tcnt_n = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == BIT_LAST) begin
            tcnt_n  = '0;
            shift_n = shift_q >> 1;
            if (bcnt_q == BCNT_LAST) begin
              state_n = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bcnt_n = bcnt_q + BCNT_W'(1);
            end
          end else begin
            tcnt_n = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tcnt_q == BIT_LAST) begin
            state_n = ST_STOP;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt_q == stop_last_q) begin
            if (!empty) pop = 1'b1;
            else        state_n = ST_IDLE;
          end else begin
            tcnt_n = tcnt_q + TCNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Frame configuration is sampled only at the pop, so later input changes
    // leave the frame in flight untouched.
    if (pop) begin
      state_n     = ST_START;
      tcnt_n      = '0;
      bcnt_n      = '0;
      shift_n     = head;
      par_en_n    = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit_n   = (parity_mode == PAR_ODD) ? ~(^head) : (^head);
      stop_last_n = stop_last(stop_mode);
    end

    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_bit_n;
      default:   tx_n = 1'b1;
    endcase
  end

  // Done is registered one cycle ahead so it lands on the final stop-tick cycle
  always_comb begin
    done_n = (state_n == ST_STOP) && (tcnt_n == stop_last_n) && tick_nxt_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      par_en_q    <= 1'b0;
      stop_last_q <= TCNT_W'(STOP_TICKS_1 - 1);
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      tcnt_q      <= tcnt_n;
      bcnt_q      <= bcnt_n;
      shift_q     <= shift_n;
      par_bit_q   <= par_bit_n;
      par_en_q    <= par_en_n;
      stop_last_q <= stop_last_n;
      tx_q        <= tx_n;
      busy_q      <= (state_n != ST_IDLE);
      done_q      <= done_n;
    end
  end

  assign stream.s_ready = ready_q;
  assign fifo_level     = count_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign tx_done_tick   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit and a 5-bit instance checked
// against hand-derived frame waveforms, timings and FIFO behaviour.
module tb_uart_tx_cfg;

  localparam int unsigned DIV_W  = 11;
  localparam int unsigned MAXCAP = 1024;

  logic             clk;
  logic             reset;
  logic [1:0]       parity_mode;
  logic [1:0]       stop_mode;
  logic [DIV_W-1:0] baud_div;
  logic             tx8, busy8, done8;
  logic [2:0]       level8;
  logic             tx5, busy5, done5;
  logic [2:0]       level5;

  uart_tx_cfg_if #(.DBIT(8)) if8 ();
  uart_tx_cfg_if #(.DBIT(5)) if5 ();

  uart_tx_cfg #(.DBIT(8), .FIFO_DEPTH(4), .DIV_W(DIV_W)) dut8 (
    .clk(clk), .reset(reset), .stream(if8), .parity_mode(parity_mode),
    .stop_mode(stop_mode), .baud_div(baud_div), .tx(tx8), .busy(busy8),
    .tx_done_tick(done8), .fifo_level(level8)
  );

  uart_tx_cfg #(.DBIT(5), .FIFO_DEPTH(4), .DIV_W(DIV_W)) dut5 (
    .clk(clk), .reset(reset), .stream(if5), .parity_mode(parity_mode),
    .stop_mode(stop_mode), .baud_div(baud_div), .tx(tx5), .busy(busy5),
    .tx_done_tick(done5), .fifo_level(level5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic cap8 [MAXCAP];
  logic cap5 [MAXCAP];
  int   dcnt8, didx8, dcnt5, didx5;

  // Expected line level at cycle i after the start bit begins
  function automatic logic exp_bit(input int i, input logic [8:0] data, input logic [1:0] pm,
                                   input int dbit, input int div);
    int   b;
    logic p;
    b = (i / (div + 1)) / 16;
    if (b == 0) return 1'b0;
    if (b <= dbit) return data[b-1];
    if ((pm == 2'b01 || pm == 2'b10) && b == dbit + 1) begin
      p = 1'b0;
      for (int k = 0; k < dbit; k++) p = p ^ data[k];
      return (pm == 2'b10) ? ~p : p;
    end
    return 1'b1;
  endfunction

  function automatic int frame_cycles(input logic [1:0] pm, input logic [1:0] sm,
                                      input int dbit, input int div);
    int pe, s;
    pe = (pm == 2'b01 || pm == 2'b10) ? 1 : 0;
    s  = (sm == 2'b00) ? 16 : (sm == 2'b01) ? 24 : 32;
    return (16 * (1 + dbit + pe) + s) * (div + 1);
  endfunction

  function automatic int wave_bad(input bit sel5, input int n, input logic [8:0] data,
                                  input logic [1:0] pm, input int dbit, input int div);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (sel5) begin
        if (cap5[i] !== exp_bit(i, data, pm, dbit, div)) bad++;
      end else begin
        if (cap8[i] !== exp_bit(i, data, pm, dbit, div)) bad++;
      end
    end
    return bad;
  endfunction

  function automatic int high_run8(input int end_idx);
    int k, r;
    r = 0;
    k = end_idx;
    while (k >= 0 && cap8[k] === 1'b1) begin r++; k--; end
    return r;
  endfunction

  task automatic capture(input int n);
    dcnt8 = 0; didx8 = -1; dcnt5 = 0; didx5 = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap8[i] = tx8;
      cap5[i] = tx5;
      if (done8) begin if (dcnt8 == 0) didx8 = i; dcnt8++; end
      if (done5) begin if (dcnt5 == 0) didx5 = i; dcnt5++; end
    end
  endtask

  task automatic push8(input logic [7:0] d);
    @(negedge clk);
    if8.s_data = d; if8.s_valid = 1'b1;
    @(negedge clk);
    if8.s_valid = 1'b0;
  endtask

  task automatic push5(input logic [4:0] d);
    @(negedge clk);
    if5.s_data = d; if5.s_valid = 1'b1;
    @(negedge clk);
    if5.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done8); end
    checks++; if (if8.s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if8.s_ready); end
    checks++; if (level8 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level8); end
    checks++; if ({tx5, busy5, level5} !== 5'b10000) begin errors++; $display("FAIL reset_dut5: tx=%b busy=%b level=%0d want 1/0/0", tx5, busy5, level5); end
  endtask

  task automatic test_basic_frame();
    int n, bad;
    parity_mode = 2'b00; stop_mode = 2'b00; baud_div = '0;
    push8(8'h55);
    checks++; if (level8 !== 3'd1) begin errors++; $display("FAIL basic_level_after_push: got %0d want 1", level8); end
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL basic_tx_before_pop: got %b want 1", tx8); end
    n = frame_cycles(2'b00, 2'b00, 8, 0);
    capture(n + 2);
    bad = wave_bad(1'b0, n + 2, 9'h055, 2'b00, 8, 0);
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_wave: %0d wrong samples want 0", bad); end
    checks++; if (dcnt8 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", dcnt8); end
    checks++; if (didx8 != 159) begin errors++; $display("FAIL basic_done_pos: got %0d want 159", didx8); end
    checks++; if (busy8 !== 1'b0 || level8 !== 3'd0) begin errors++; $display("FAIL basic_idle_after: busy=%b level=%0d want 0/0", busy8, level8); end
  endtask

  task automatic test_parity();
    int bad;
    baud_div = '0; stop_mode = 2'b00;
    parity_mode = 2'b01;
    push8(8'h07);
    capture(178);
    bad = wave_bad(1'b0, 178, 9'h007, 2'b01, 8, 0);
    checks++; if (bad != 0) begin errors++; $display("FAIL even_wave: %0d wrong samples want 0", bad); end
    checks++; if (cap8[144] !== 1'b1) begin errors++; $display("FAIL even_parity_bit: got %b want 1", cap8[144]); end
    checks++; if (didx8 != 175) begin errors++; $display("FAIL even_done_pos: got %0d want 175", didx8); end
    parity_mode = 2'b10;
    push8(8'h07);
    capture(178);
    bad = wave_bad(1'b0, 178, 9'h007, 2'b10, 8, 0);
    checks++; if (bad != 0) begin errors++; $display("FAIL odd_wave: %0d wrong samples want 0", bad); end
    checks++; if (cap8[144] !== 1'b0) begin errors++; $display("FAIL odd_parity_bit: got %b want 0", cap8[144]); end
    checks++; if (didx8 != 175) begin errors++; $display("FAIL odd_done_pos: got %0d want 175", didx8); end
  endtask

  task automatic test_stop_modes();
    int n, bad, run;
    parity_mode = 2'b00; stop_mode = 2'b01; baud_div = 11'd3;
    push8(8'h23);
    fork
      begin
        repeat (100) @(negedge clk);
        stop_mode = 2'b10; baud_div = '0; parity_mode = 2'b01;
      end
    join_none
    n = frame_cycles(2'b00, 2'b01, 8, 3);
    capture(n + 2);
    bad = wave_bad(1'b0, n + 2, 9'h023, 2'b00, 8, 3);
    run = high_run8(didx8);
    checks++; if (bad != 0) begin errors++; $display("FAIL stop15_wave: %0d wrong samples want 0", bad); end
    checks++; if (didx8 != 671) begin errors++; $display("FAIL stop15_done_pos: got %0d want 671", didx8); end
    checks++; if (run != 96) begin errors++; $display("FAIL stop15_high_len: got %0d want 96", run); end
    parity_mode = 2'b00; baud_div = 11'd3;
    push8(8'h23);
    n = frame_cycles(2'b00, 2'b10, 8, 3);
    capture(n + 2);
    bad = wave_bad(1'b0, n + 2, 9'h023, 2'b00, 8, 3);
    run = high_run8(didx8);
    checks++; if (bad != 0) begin errors++; $display("FAIL stop2_wave: %0d wrong samples want 0", bad); end
    checks++; if (didx8 != 703) begin errors++; $display("FAIL stop2_done_pos: got %0d want 703", didx8); end
    checks++; if (run != 128) begin errors++; $display("FAIL stop2_high_len: got %0d want 128", run); end
  endtask

  task automatic test_dbit5_illegal_parity();
    int bad;
    parity_mode = 2'b11; stop_mode = 2'b00; baud_div = '0;
    push5(5'h1F);
    capture(114);
    bad = wave_bad(1'b1, 114, 9'h01F, 2'b11, 5, 0);
    checks++; if (bad != 0) begin errors++; $display("FAIL dbit5_wave: %0d wrong samples want 0", bad); end
    checks++; if (didx5 != 111 || dcnt5 != 1) begin errors++; $display("FAIL dbit5_done: pos=%0d count=%0d want 111/1", didx5, dcnt5); end
    checks++; if (dcnt8 != 0) begin errors++; $display("FAIL dbit5_dut8_quiet: got %0d dones want 0", dcnt8); end
  endtask

  task automatic test_reset_midframe();
    int c, lows, dones;
    parity_mode = 2'b00; stop_mode = 2'b00; baud_div = '0;
    @(negedge clk);
    if8.s_data = 8'h00; if8.s_valid = 1'b1;
    repeat (3) @(negedge clk);
    if8.s_valid = 1'b0;
    c = 0;
    while (!done8 && c < 400) begin @(negedge clk); c++; end
    checks++; if (c >= 400) begin errors++; $display("FAIL rst_first_done: timeout after %0d cycles want done", c); end
    repeat (30) @(negedge clk);
    checks++; if (tx8 !== 1'b0 || busy8 !== 1'b1 || level8 !== 3'd1) begin errors++; $display("FAIL rst_pre_state: tx=%b busy=%b level=%0d want 0/1/1", tx8, busy8, level8); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b want 1", tx8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy8); end
    checks++; if (level8 !== 3'd0) begin errors++; $display("FAIL rst_mid_level: got %0d want 0", level8); end
    checks++; if (if8.s_ready !== 1'b1 || done8 !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_done: ready=%b done=%b want 1/0", if8.s_ready, done8); end
    reset = 1'b0;
    lows = 0; dones = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx8 !== 1'b1) lows++;
      if (done8) dones++;
    end
    checks++; if (lows != 0 || dones != 0) begin errors++; $display("FAIL rst_fifo_discarded: low=%0d done=%0d want 0/0", lows, dones); end
  endtask

  task automatic test_fifo_full_back_to_back();
    logic [7:0] w [6];
    int   idx, acc, c, dn, gap_bad, delta_bad, last_c;
    logic sampled, prev_done;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h5A; w[5] = 8'h66;
    parity_mode = 2'b00; stop_mode = 2'b00; baud_div = 11'd100;
    idx = 0; acc = 0;
    @(negedge clk);
    if8.s_data = w[0]; if8.s_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sampled = if8.s_ready;
      @(negedge clk);
      if (if8.s_valid && sampled) begin
        acc++; idx++;
        if (idx < 6) if8.s_data = w[idx];
        else         if8.s_valid = 1'b0;
      end
    end
    checks++; if (acc != 5) begin errors++; $display("FAIL fifo_accepted: got %0d want 5", acc); end
    checks++; if (if8.s_ready !== 1'b0) begin errors++; $display("FAIL fifo_ready_full: got %b want 0", if8.s_ready); end
    checks++; if (level8 !== 3'd4) begin errors++; $display("FAIL fifo_level_full: got %0d want 4", level8); end
    if8.s_valid = 1'b0;
    baud_div = '0;
    c = 0; dn = 0; gap_bad = 0; delta_bad = 0; last_c = 0; prev_done = 1'b0;
    while (dn < 5 && c < 20000) begin
      @(negedge clk); c++;
      if (prev_done && tx8 !== 1'b0) gap_bad++;
      prev_done = done8;
      if (done8) begin
        if (dn >= 1 && (c - last_c) != 160) delta_bad++;
        last_c = c;
        dn++;
      end
    end
    checks++; if (dn != 5) begin errors++; $display("FAIL b2b_frames: got %0d dones want 5", dn); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_gap: %0d frames not followed by start want 0", gap_bad); end
    checks++; if (delta_bad != 0) begin errors++; $display("FAIL b2b_frame_len: %0d frames not 160 cycles want 0", delta_bad); end
    @(negedge clk);
    checks++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || level8 !== 3'd0) begin errors++; $display("FAIL b2b_idle_after: tx=%b busy=%b level=%0d want 1/0/0", tx8, busy8, level8); end
  endtask

  initial begin
    reset = 1'b1;
    parity_mode = 2'b00; stop_mode = 2'b00; baud_div = '0;
    if8.s_data = '0; if8.s_valid = 1'b0;
    if5.s_data = '0; if5.s_valid = 1'b0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_stop_modes();
    test_dbit5_illegal_parity();
    test_reset_midframe();
    test_fifo_full_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter: the next-generation transmit path of the UART block. It accepts bytes through a ready/valid stream into an internal FIFO and serialises them LSB-first with a start bit, optional parity and 1, 1.5 or 2 stop bits, using a 16x oversampling tick from an integrated programmable baud divider. It sits between the host-side data producer and the TX pin, and supports back-to-back frames with no idle gap.

## Interface
- DBIT, 8: data bits per frame, legal 5..9
- FIFO_DEPTH, 4: input FIFO entries, power of two, >=2
- DIV_W, 11: width of `baud_div`
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high; one clock, one reset
- `s_data` in DBIT: byte to transmit
- `s_valid` in 1: producer has data
- `s_ready` out 1: FIFO not full; a word is accepted when `s_valid && s_ready` at a rising edge
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none
- `stop_mode` in 2: 00 one stop bit (16 ticks), 01 1.5 (24 ticks), 10 or 11 two (32 ticks)
- `baud_div` in DIV_W: tick period = `baud_div`+1 clk cycles (0 gives a tick every cycle)
- `tx` out 1: serial line, idle high
- `busy` out 1: high while the FSM is not IDLE
- `tx_done_tick` out 1: one-cycle pulse on the last cycle of each frame's stop period
- `fifo_level` out clog2(FIFO_DEPTH+1): current FIFO occupancy

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE: drive `tx`=1. When the FIFO is non-empty, pop the head into the shift register, latch `parity_mode`, `stop_mode` and `baud_div` into frame-config registers, restart the divider, then go to START.
- START: drive `tx`=0 for 16 ticks, then go to DATA with the bit counter at 0.
- DATA: drive `tx` from shift[0]. Every 16 ticks, shift right; after DBIT bits go to PARITY if parity is enabled, otherwise STOP.
- PARITY: drive ^data for even parity or ~^data for odd parity, for 16 ticks. Parity is computed from the popped word, not the shifted register.
- STOP: drive `tx`=1 for 16, 24 or 32 ticks, set by the latched `stop_mode`. On the final tick, pulse `tx_done_tick`. If the FIFO is non-empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- Config inputs may change at any time. They affect only frames popped after the change.
- Tick counter is 4 bits for START/DATA/PARITY and 5 bits for STOP. The divider counter is DIV_W bits and wraps at the latched `baud_div`.
- `reset` mid-frame aborts the frame. The next cycle shows the reset values, and FIFO contents are discarded.
- Illegal encodings: `parity_mode`=11 and `stop_mode`=11 behave as documented above and never hang the FSM.

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_done_tick`=0, `s_ready`=1, `fifo_level`=0, state IDLE.
- `tx` is a registered output with no combinational path from any input.
- Push at edge N gives `fifo_level` +1 after N. An IDLE FSM pops at edge N+1, so `tx` goes low after edge N+1.
- Start bit, each data bit and the parity bit each last exactly 16·(`baud_div`+1) clk cycles.
- Frame length = 16·(1+DBIT+P)+S ticks, where P is 0 or 1 and S is 16, 24 or 32.
- `s_ready` = !full, decoded from registers. A push into a full FIFO is not accepted, even if a pop occurs in the same cycle.
- Push and pop in the same cycle: `fifo_level` is unchanged.
- Back-to-back frames: the next start bit begins on the cycle immediately after the `tx_done_tick` cycle.

## Structure
- Shared `uart_pkg` holds:
  - state encodings;
  - `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - `STOP_1`/`STOP_1P5`/`STOP_2`;
  - stop-tick constants 16, 24 and 32;
  - `OVERSAMPLE`=16.
- One sub-module, `uart_baud_gen`, contains the DIV_W-bit divider with a synchronous restart input, producing a single-cycle tick output.
- The FIFO is inline: a register array with read/write pointers and a count.

## Test plan
- DBIT=8, `baud_div`=0, no parity, 1 stop, push 0x55:
  - `tx` low for cycles 2–17, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles;
  - `tx_done_tick` asserted exactly once, 160 cycles after the start bit begins.
- Even parity, push 0x07 → parity bit 1. Odd parity, push 0x07 → parity bit 0. Both frames are 176 cycles at `baud_div`=0.
- `stop_mode`=01 and then 10, `baud_div`=3 → stop high for 96 and then 128 cycles. Changing `stop_mode` mid-frame does not alter the current frame.
- FIFO_DEPTH=4, `baud_div`=100, `s_valid` held high with 6 words:
  - exactly 5 words accepted (1 in flight, 4 queued), `s_ready` then low and `fifo_level`=4;
  - all 5 frames emitted back-to-back with no high gap beyond the stop bits.
- Assert `reset` for one cycle during DATA of the 2nd frame: the next cycle shows `tx`=1, `busy`=0, `fifo_level`=0 and `s_ready`=1, with no `tx_done_tick`.
- DBIT=5, push 0x1F with `parity_mode`=11 → no parity bit, frame of 112 ticks.
